mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_pkg.sv | 35 +++
 rtl/mem_lane_align.sv | 77 +++++++
 rtl/mem_access_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types for the memory access controller.
//   size_e      - request access size encodings (byte, half, word, illegal)
//   state_e     - controller FSM states
//   bad_access  - helper that flags illegal sizes and misaligned addresses
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    RWAIT = 3'd2,
    MERGE = 3'd3,
    WR    = 3'd4,
    RESP  = 3'd5
  } state_e;

  // 1 when the size is illegal or the address is not naturally aligned.
  function automatic logic bad_access(input size_e size, input logic [1:0] lsb);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lsb[0];
      SZ_WORD: bad = |lsb;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane handling for sub-word accesses.
// Ports:
//   size     in  2   access size (size_e)
//   sign_ext in  1   sign-extend extracted byte/half
//   lane     in  2   byte address within the word (addr[1:0])
//   ld_word  in  32  word read from memory, source for load extraction
//   st_word  in  32  captured word to be partially overwritten
//   st_data  in  16  right-aligned store data (only low byte/half is used)
//   ld_data  out 32  extracted, extended load result
//   merged   out 32  st_word with the addressed byte/half replaced
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  lane,
  input  logic [31:0] ld_word,
  input  logic [31:0] st_word,
  input  logic [15:0] st_data,
  output logic [31:0] ld_data,
  output logic [31:0] merged
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] st_repl;
  logic [3:0]  byte_en;

  // Byte/half selection by lane.
  always_comb begin
    ld_byte = ld_word[8*lane +: 8];
    ld_half = lane[1] ? ld_word[31:16] : ld_word[15:0];
  end

  always_comb begin
    ld_data = 32'h0;
    case (size_e'(size))
      SZ_BYTE: ld_data = {{24{sign_ext & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{sign_ext & ld_half[15]}}, ld_half};
      SZ_WORD: ld_data = ld_word;
      default: ld_data = 32'h0;
    endcase
  end

  // Store data is replicated into every lane; byte enables then pick which
  // lanes of the captured word get replaced.
  always_comb begin
    st_repl = 32'h0;
    byte_en = 4'b0000;
    case (size_e'(size))
      SZ_BYTE: begin
        st_repl = {4{st_data[7:0]}};
        byte_en = 4'b0001 << lane;
      end
      SZ_HALF: begin
        st_repl = {2{st_data}};
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
      end
      SZ_WORD: begin
        st_repl = {2{st_data}};
        byte_en = 4'b0000;
      end
      default: begin
        st_repl = 32'h0;
        byte_en = 4'b0000;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[8*gi +: 8] = byte_en[gi] ? st_repl[8*gi +: 8] : st_word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte/half/word load-store controller in front of a
// word-wide data memory with fixed read latency. Sub-word stores are done
// as read-modify-write.
// Parameters:
//   MEM_LATENCY  cycles from the read strobe to valid mem_rdata (1..7)
//   ADDR_W       request byte-address width
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake
//   req_write, req_size, req_signed request attributes
//   req_addr, req_wdata             byte address, right-aligned store data
//   mem_addr, mem_wdata             word index, full write word
//   mem_enable, mem_readwrite       access strobe, 1 = write
//   mem_rdata                       read word
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata, rsp_err              load result, misaligned/illegal flag
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_enable,
  output logic              mem_readwrite,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  // RWAIT lasts MEM_LATENCY cycles: counter loads LATENCY-1 and exits at 0.
  localparam logic [2:0] WAIT_INIT = 3'(MEM_LATENCY - 1);

  state_e      state_reg, state_next;
  logic [2:0]  wait_cnt_reg;
  logic        write_reg;
  logic [1:0]  size_reg;
  logic        signed_reg;
  logic [1:0]  lane_reg;
  logic [15:0] wdata_lo_reg;
  logic [31:0] rword_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wdata_reg;
  logic [31:0] rsp_rdata_reg;
  logic        rsp_err_reg;

  logic        req_bad;
  logic        accept;
  logic        req_is_word;
  logic [31:0] word_idx;
  logic [31:0] ld_data;
  logic [31:0] merged;

  logic [ADDR_W-1:0] addr_shift;
  assign addr_shift = req_addr >> 2;

  generate
    if (ADDR_W >= 32) begin : g_idx_wide
      assign word_idx = addr_shift[31:0];
    end else begin : g_idx_narrow
      assign word_idx = {{(32-ADDR_W){1'b0}}, addr_shift};
    end
  endgenerate

  assign req_bad     = bad_access(size_e'(req_size), req_addr[1:0]);
  assign req_is_word = (size_e'(req_size) == SZ_WORD);
  assign accept      = req_valid && req_ready;

  mem_lane_align u_align (
    .size     (size_reg),
    .sign_ext (signed_reg),
    .lane     (lane_reg),
    .ld_word  (mem_rdata),
    .st_word  (rword_reg),
    .st_data  (wdata_lo_reg),
    .ld_data  (ld_data),
    .merged   (merged)
  );

  // Next state and strobes
  always_comb begin
    state_next    = state_reg;
    req_ready     = 1'b0;
    mem_enable    = 1'b0;
    mem_readwrite = 1'b0;
    rsp_valid     = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_bad)                      state_next = RESP;
          else if (req_write && req_is_word) state_next = WR;
          else                              state_next = RD;
        end
      end
      RD: begin
        mem_enable = 1'b1;
        state_next = RWAIT;
      end
      RWAIT: begin
        if (wait_cnt_reg == 3'd0) state_next = write_reg ? MERGE : RESP;
      end
      MERGE: state_next = WR;
      WR: begin
        mem_enable    = 1'b1;
        mem_readwrite = 1'b1;
        state_next    = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= 3'd0;
      write_reg     <= 1'b0;
      size_reg      <= 2'b00;
      signed_reg    <= 1'b0;
      lane_reg      <= 2'b00;
      wdata_lo_reg  <= 16'h0;
      rword_reg     <= 32'h0;
      mem_addr_reg  <= 32'h0;
      mem_wdata_reg <= 32'h0;
      rsp_rdata_reg <= 32'h0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            write_reg     <= req_write;
            size_reg      <= req_size;
            signed_reg    <= req_signed;
            lane_reg      <= req_addr[1:0];
            wdata_lo_reg  <= req_wdata[15:0];
            mem_addr_reg  <= word_idx;
            rsp_err_reg   <= req_bad;
            rsp_rdata_reg <= 32'h0;
            // Word stores need no read; the write word is known now.
            if (req_write && req_is_word && !req_bad) mem_wdata_reg <= req_wdata;
          end
        end
        RD: wait_cnt_reg <= WAIT_INIT;
        RWAIT: begin
          if (wait_cnt_reg == 3'd0) begin
            if (write_reg) rword_reg     <= mem_rdata;
            else           rsp_rdata_reg <= ld_data;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 3'd1;
          end
        end
        MERGE: mem_wdata_reg <= merged;
        RESP: begin
          if (rsp_ready) begin
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

endmodule
